mc_port_arbiter: RTL and testbench

//  Shares one Convey MC request/response port among NUM_REQ requesters (PHOLD cores, event-queue spill unit).

---
 rtl/mc_port_arbiter_if.sv | 64 ++++++
 rtl/mc_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mc_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mc_port_arbiter_if.sv
// Bus bundle between the requester array, the MC port and mc_port_arbiter.
// Optional statistics outputs are present when MC_ARB_STATS_EN is defined.
interface mc_port_arbiter_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MC_RTNCTL_WIDTH = 32
);
  // requester side
  logic [NUM_REQ-1:0]                 req_vld;
  logic [3*NUM_REQ-1:0]               req_cmd;
  logic [4*NUM_REQ-1:0]               req_scmd;
  logic [48*NUM_REQ-1:0]              req_vadr;
  logic [2*NUM_REQ-1:0]               req_size;
  logic [MC_RTNCTL_WIDTH*NUM_REQ-1:0] req_rtnctl;
  logic [64*NUM_REQ-1:0]              req_data;
  logic [NUM_REQ-1:0]                 req_stall;
  logic [NUM_REQ-1:0]                 rs_vld;
  logic [2:0]                         rs_cmd;
  logic [3:0]                         rs_scmd;
  logic [MC_RTNCTL_WIDTH-1:0]         rs_rtnctl;
  logic [63:0]                        rs_data;
  logic [NUM_REQ-1:0]                 rs_stall;
  // MC side
  logic                               mc_rq_vld;
  logic [2:0]                         mc_rq_cmd;
  logic [3:0]                         mc_rq_scmd;
  logic [47:0]                        mc_rq_vadr;
  logic [1:0]                         mc_rq_size;
  logic [MC_RTNCTL_WIDTH-1:0]         mc_rq_rtnctl;
  logic [63:0]                        mc_rq_data;
  logic                               mc_rq_flush;
  logic                               mc_rq_stall;
  logic                               mc_rs_vld;
  logic [2:0]                         mc_rs_cmd;
  logic [3:0]                         mc_rs_scmd;
  logic [MC_RTNCTL_WIDTH-1:0]         mc_rs_rtnctl;
  logic [63:0]                        mc_rs_data;
  logic                               mc_rs_stall;
`ifdef MC_ARB_STATS_EN
  logic [64*NUM_REQ-1:0]              grant_cnt;
  logic [63:0]                        mc_stall_cnt;
`endif

  modport slave (
`ifdef MC_ARB_STATS_EN
    output grant_cnt, mc_stall_cnt,
`endif
    input  req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data, rs_stall,
    output req_stall, rs_vld, rs_cmd, rs_scmd, rs_rtnctl, rs_data,
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data,
    output mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );

  modport master (
`ifdef MC_ARB_STATS_EN
    input  grant_cnt, mc_stall_cnt,
`endif
    output req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data, rs_stall,
    input  req_stall, rs_vld, rs_cmd, rs_scmd, rs_rtnctl, rs_data,
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data,
    input  mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );
endinterface

// File: rtl/mc_port_arbiter.sv
// Round-robin sharing of one Convey MC port among NUM_REQ requesters; requester ID rides in the
// top rtnctl bits and steers responses back. Define MC_ARB_STATS_EN to add grant/stall counters.
module mc_port_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_WID          = 2,
  parameter int unsigned MC_RTNCTL_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_port_arbiter_if.slave  bus
);
  localparam int unsigned LOW_W = MC_RTNCTL_WIDTH - ID_WID;
  localparam int unsigned CW    = ID_WID + 1;

  logic [ID_WID-1:0]          ptr;
  logic                       can_load;
  logic [NUM_REQ-1:0]         grant;
  logic                       found;
  logic [ID_WID-1:0]          gnt_idx;
  logic [CW-1:0]              cand;
  logic [2:0]                 sel_cmd;
  logic [3:0]                 sel_scmd;
  logic [47:0]                sel_vadr;
  logic [1:0]                 sel_size;
  logic [MC_RTNCTL_WIDTH-1:0] sel_rtnctl;
  logic [63:0]                sel_data;
  logic [NUM_REQ-1:0]         rs_hit;
  logic                       unused_rtnctl_id;

  logic                       rq_vld;
  logic [2:0]                 rq_cmd;
  logic [3:0]                 rq_scmd;
  logic [47:0]                rq_vadr;
  logic [1:0]                 rq_size;
  logic [MC_RTNCTL_WIDTH-1:0] rq_rtnctl;
  logic [63:0]                rq_data;
  logic [NUM_REQ-1:0]         rs_vld_q;
  logic [2:0]                 rs_cmd_q;
  logic [3:0]                 rs_scmd_q;
  logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_q;
  logic [63:0]                rs_data_q;

  assign can_load = !rq_vld || !bus.mc_rq_stall;

  // Round-robin search starting at ptr, wrapping at NUM_REQ-1
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (can_load && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = CW'(ptr) + CW'(k);
        if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
        if (!found && bus.req_vld[cand[ID_WID-1:0]]) begin
          found   = 1'b1;
          gnt_idx = cand[ID_WID-1:0];
        end
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  // Field mux for the granted requester
  always_comb begin
    sel_cmd    = '0;
    sel_scmd   = '0;
    sel_vadr   = '0;
    sel_size   = '0;
    sel_rtnctl = '0;
    sel_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_cmd    = bus.req_cmd[3*i +: 3];
        sel_scmd   = bus.req_scmd[4*i +: 4];
        sel_vadr   = bus.req_vadr[48*i +: 48];
        sel_size   = bus.req_size[2*i +: 2];
        sel_rtnctl = bus.req_rtnctl[MC_RTNCTL_WIDTH*i +: MC_RTNCTL_WIDTH];
        sel_data   = bus.req_data[64*i +: 64];
      end
    end
  end

  // Requester-owned ID bits are overwritten, so their inbound values are intentionally dropped
  always_comb begin
    unused_rtnctl_id = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      unused_rtnctl_id = unused_rtnctl_id ^ (^bus.req_rtnctl[MC_RTNCTL_WIDTH*i+LOW_W +: ID_WID]);
  end

  // Response decode; IDs with no matching requester produce no hit and are dropped
  always_comb begin
    rs_hit = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rs_hit[i] = bus.mc_rs_vld && (bus.mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_WID] == ID_WID'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      rq_vld    <= 1'b0;
      rq_cmd    <= '0;
      rq_scmd   <= '0;
      rq_vadr   <= '0;
      rq_size   <= '0;
      rq_rtnctl <= '0;
      rq_data   <= '0;
    end else if (can_load) begin
      rq_vld <= found;
      if (found) begin
        ptr       <= (gnt_idx == ID_WID'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WID'(1);
        rq_cmd    <= sel_cmd;
        rq_scmd   <= sel_scmd;
        rq_vadr   <= sel_vadr;
        rq_size   <= sel_size;
        rq_rtnctl <= {gnt_idx, sel_rtnctl[LOW_W-1:0]};
        rq_data   <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_vld_q    <= '0;
      rs_cmd_q    <= '0;
      rs_scmd_q   <= '0;
      rs_rtnctl_q <= '0;
      rs_data_q   <= '0;
    end else begin
      rs_vld_q <= rs_hit;
      if (|rs_hit) begin
        rs_cmd_q    <= bus.mc_rs_cmd;
        rs_scmd_q   <= bus.mc_rs_scmd;
        rs_rtnctl_q <= {{ID_WID{1'b0}}, bus.mc_rs_rtnctl[LOW_W-1:0]};
        rs_data_q   <= bus.mc_rs_data;
      end
    end
  end

`ifdef MC_ARB_STATS_EN
  logic [63:0] gcnt [NUM_REQ];
  logic [63:0] scnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
      scnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) gcnt[i] <= gcnt[i] + 64'd1;
      if (rq_vld && bus.mc_rq_stall) scnt <= scnt + 64'd1;
    end
  end

  always_comb begin
    bus.grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.grant_cnt[64*i +: 64] = gcnt[i];
  end
  assign bus.mc_stall_cnt = scnt;
`endif

  assign bus.req_stall    = reset ? '1 : ~grant;
  assign bus.mc_rq_vld    = rq_vld;
  assign bus.mc_rq_cmd    = rq_cmd;
  assign bus.mc_rq_scmd   = rq_scmd;
  assign bus.mc_rq_vadr   = rq_vadr;
  assign bus.mc_rq_size   = rq_size;
  assign bus.mc_rq_rtnctl = rq_rtnctl;
  assign bus.mc_rq_data   = rq_data;
  assign bus.mc_rq_flush  = 1'b0;
  assign bus.mc_rs_stall  = |bus.rs_stall;
  assign bus.rs_vld       = rs_vld_q;
  assign bus.rs_cmd       = rs_cmd_q;
  assign bus.rs_scmd      = rs_scmd_q;
  assign bus.rs_rtnctl    = rs_rtnctl_q;
  assign bus.rs_data      = rs_data_q;
endmodule

// File: tb/tb_mc_port_arbiter.sv
// Randomized bench for mc_port_arbiter against a cycle-level behavioural model of the arbitration
// and response rules. Compile with +define+MC_ARB_STATS_EN to also check the statistics counters.
module tb_mc_port_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned RW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_port_arbiter_if #(.NUM_REQ(N), .MC_RTNCTL_WIDTH(RW)) bus ();

  mc_port_arbiter #(.NUM_REQ(N), .ID_WID(2), .MC_RTNCTL_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int              m_ptr;
  bit              m_vld;
  logic [2:0]      m_cmd;
  logic [3:0]      m_scmd;
  logic [47:0]     m_vadr;
  logic [1:0]      m_size;
  logic [31:0]     m_rtn;
  logic [63:0]     m_data;
  logic [3:0]      m_rs_vld;
  logic [2:0]      m_rs_cmd;
  logic [3:0]      m_rs_scmd;
  logic [31:0]     m_rs_rtn;
  logic [63:0]     m_rs_data;
  longint unsigned m_gcnt [N];
  longint unsigned m_scnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_vld = 0;
    m_cmd = '0; m_scmd = '0; m_vadr = '0; m_size = '0; m_rtn = '0; m_data = '0;
    m_rs_vld = '0; m_rs_cmd = '0; m_rs_scmd = '0; m_rs_rtn = '0; m_rs_data = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    m_scnt = 0;
  endtask

  // Requester granted this cycle, or -1 when the output slot cannot accept
  function automatic int find_grant();
    if (m_vld && bus.mc_rq_stall) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req_vld[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clock();
    int g;
    logic [31:0] r;
    logic [1:0]  id;
    if (m_vld && bus.mc_rq_stall) m_scnt++;
    g = find_grant();
    if (!m_vld || !bus.mc_rq_stall) begin
      m_vld = (g >= 0);
      if (g >= 0) begin
        r      = bus.req_rtnctl[g*32 +: 32];
        m_cmd  = bus.req_cmd[g*3 +: 3];
        m_scmd = bus.req_scmd[g*4 +: 4];
        m_vadr = bus.req_vadr[g*48 +: 48];
        m_size = bus.req_size[g*2 +: 2];
        m_data = bus.req_data[g*64 +: 64];
        m_rtn  = {g[1:0], r[29:0]};
        m_ptr  = (g + 1) % N;
        m_gcnt[g]++;
      end
    end
    m_rs_vld = '0;
    if (bus.mc_rs_vld) begin
      id = bus.mc_rs_rtnctl[31:30];
      if (int'(id) < N) begin
        m_rs_vld[id] = 1'b1;
        m_rs_cmd     = bus.mc_rs_cmd;
        m_rs_scmd    = bus.mc_rs_scmd;
        m_rs_rtn     = {2'b00, bus.mc_rs_rtnctl[29:0]};
        m_rs_data    = bus.mc_rs_data;
      end
    end
  endtask

  task automatic check_outputs();
    int g;
    logic [3:0] exp_stall;
    g = find_grant();
    exp_stall = 4'hf;
    if (g >= 0) exp_stall[g] = 1'b0;
    chk("req_stall",    64'(bus.req_stall),    64'(exp_stall));
    chk("mc_rq_vld",    64'(bus.mc_rq_vld),    64'(m_vld));
    chk("mc_rq_cmd",    64'(bus.mc_rq_cmd),    64'(m_cmd));
    chk("mc_rq_scmd",   64'(bus.mc_rq_scmd),   64'(m_scmd));
    chk("mc_rq_vadr",   64'(bus.mc_rq_vadr),   64'(m_vadr));
    chk("mc_rq_size",   64'(bus.mc_rq_size),   64'(m_size));
    chk("mc_rq_rtnctl", 64'(bus.mc_rq_rtnctl), 64'(m_rtn));
    chk("mc_rq_data",   bus.mc_rq_data,        m_data);
    chk("mc_rq_flush",  64'(bus.mc_rq_flush),  64'(0));
    chk("mc_rs_stall",  64'(bus.mc_rs_stall),  64'(|bus.rs_stall));
    chk("rs_vld",       64'(bus.rs_vld),       64'(m_rs_vld));
    chk("rs_cmd",       64'(bus.rs_cmd),       64'(m_rs_cmd));
    chk("rs_scmd",      64'(bus.rs_scmd),      64'(m_rs_scmd));
    chk("rs_rtnctl",    64'(bus.rs_rtnctl),    64'(m_rs_rtn));
    chk("rs_data",      bus.rs_data,           m_rs_data);
`ifdef MC_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("grant_cnt%0d", i), bus.grant_cnt[64*i +: 64], m_gcnt[i]);
    chk("mc_stall_cnt", bus.mc_stall_cnt, m_scnt);
`endif
  endtask

  task automatic drive_inputs(input logic [3:0] rv, input logic st, input logic rsv);
    bus.req_vld = rv;
    for (int i = 0; i < N; i++) begin
      bus.req_cmd[i*3 +: 3]     = 3'($urandom);
      bus.req_scmd[i*4 +: 4]    = 4'($urandom);
      bus.req_vadr[i*48 +: 48]  = {16'($urandom), 32'($urandom)};
      bus.req_size[i*2 +: 2]    = 2'($urandom);
      bus.req_rtnctl[i*32 +: 32] = 32'($urandom);
      bus.req_data[i*64 +: 64]  = {32'($urandom), 32'($urandom)};
    end
    bus.rs_stall     = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
    bus.mc_rq_stall  = st;
    bus.mc_rs_vld    = rsv;
    bus.mc_rs_cmd    = 3'($urandom);
    bus.mc_rs_scmd   = 4'($urandom);
    bus.mc_rs_rtnctl = 32'($urandom);
    bus.mc_rs_data   = {32'($urandom), 32'($urandom)};
  endtask

  // Drive at posedge+1, check at negedge, advance model at posedge
  task automatic run_cycle(input logic [3:0] rv, input logic st, input logic rsv);
    drive_inputs(rv, st, rsv);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_inputs(4'hf, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_stall", 64'(bus.req_stall), 64'hf);
    chk("rst_mc_rq_vld", 64'(bus.mc_rq_vld), 64'(0));
    chk("rst_rs_vld",    64'(bus.rs_vld),    64'(0));
    reset = 1'b0;

    // all requesters busy, MC free: strict 0,1,2,3 rotation
    repeat (40) run_cycle(4'hf, 1'b0, 1'($urandom));
`ifdef MC_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("gcnt40_%0d", i), bus.grant_cnt[64*i +: 64], 64'd10);
`endif

    // MC backpressure with a held request
    repeat (5) run_cycle(4'hf, 1'b1, 1'b0);
`ifdef MC_ARB_STATS_EN
    chk("stall_cnt5", bus.mc_stall_cnt, 64'd5);
`endif
    repeat (4) run_cycle(4'hf, 1'b0, 1'b0);
    repeat (6) run_cycle(4'b0100, 1'b0, 1'b1);

    repeat (300) run_cycle(4'($urandom), 1'($urandom_range(0, 9) < 3), 1'($urandom));

    // reset while a request is held and ptr has moved to 2
    run_cycle(4'b0010, 1'b0, 1'b0);
    chk("pre_rst_vld", 64'(bus.mc_rq_vld), 64'(1));
    bus.req_vld = 4'hf;
    #2 reset = 1'b1;
    #1;
    chk("midrst_mc_rq_vld", 64'(bus.mc_rq_vld), 64'(0));
    chk("midrst_req_stall", 64'(bus.req_stall), 64'hf);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    run_cycle(4'hf, 1'b0, 1'b0);
    chk("post_rst_id", 64'(bus.mc_rq_rtnctl[31:30]), 64'(0));

    repeat (100) run_cycle(4'($urandom), 1'($urandom_range(0, 9) < 3), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
